proc_ready_sel: RTL

- Consumer side of the process-timer ready vector: takes the 32 per-process ready levels and latches rising edges into sticky pending bits.
- A round-robin scanner selects the next pending, enabled process.
- Scheduler software reads the selected process number over the IO bus, then claims it; the scanner then resumes from the next process number.
- Sits on the same IO bus as the process timers. Its rdy_in port is wired directly to the process timers' proc_rdy output.

---
 rtl/proc_ready_sel_pkg.sv | 23 ++
 rtl/proc_ready_sel_rr_scan.sv | 82 ++++++++
 rtl/proc_ready_sel.sv | 84 ++++++++
 3 files changed

// File: rtl/proc_ready_sel_pkg.sv
// Shared constants for the process-ready selector: control bits, read-word
// field positions and the scanner state encoding.
package proc_ready_sel_pkg;

  localparam int NPROC  = 32;
  localparam int SCAN_W = 5;

  localparam int CTRL_CLAIM = 0;
  localparam int CTRL_EN    = 1;
  localparam int CTRL_DIS   = 2;
  localparam int CTRL_CLR   = 3;
  localparam int CTRL_FORCE = 4;

  localparam int VALID_BIT = 31;
  localparam int CAND_LSB  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } scan_state_e;

endpackage

// File: rtl/proc_ready_sel_rr_scan.sv
// Round-robin scanner: walks one process index per cycle over the
// pending-and-enabled vector and holds the first hit until it is claimed.
module proc_ready_sel_rr_scan
  import proc_ready_sel_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NPROC-1:0]  avail,
  input  logic              claim,
  input  logic              clr_all,
  output logic [1:0]        state_o,
  output logic [SCAN_W-1:0] cand_o
);

  scan_state_e       state_q, state_d;
  logic [SCAN_W-1:0] s_q, s_d;
  logic [SCAN_W-1:0] cnt_q, cnt_d;
  logic [SCAN_W-1:0] cand_q, cand_d;
  logic [SCAN_W-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|avail) begin
          s_d     = ptr_q;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (avail[s_q]) begin
          cand_d  = s_q;
          state_d = ST_HOLD;
        end else begin
          s_d   = s_q + 5'd1;
          cnt_d = cnt_q + 5'd1;
          // the 32nd miss ends the sweep
          if (cnt_q == 5'd31) state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (claim) begin
          ptr_d   = cand_q + 5'd1;
          s_d     = cand_q + 5'd1;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end else if (!avail[cand_q]) begin
          s_d     = cand_q + 5'd1;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr_all) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      cand_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      ptr_q   <= ptr_d;
    end
  end

  assign state_o = state_q;
  assign cand_o  = cand_q;

endmodule

// File: rtl/proc_ready_sel.sv
// Process-ready selector: latches rising edges of the timer ready vector into
// sticky pending bits and presents the round-robin choice on the IO bus.
module proc_ready_sel
  import proc_ready_sel_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  input  logic [31:0] rdy_in
);

  // Bus handshake: a transfer happens on every cycle stb is high; ack
  // mirrors stb so there are no wait states and nothing to stall on.
  logic [NPROC-1:0]  rdy_q;
  logic [NPROC-1:0]  pending_q, pending_d;
  logic [NPROC-1:0]  mask_q, mask_d;
  logic [NPROC-1:0]  rise;
  logic [NPROC-1:0]  avail;
  logic              wr, rd;
  logic              claim_acc, clr_all, hold;
  logic [SCAN_W-1:0] proc_sel;
  logic [SCAN_W-1:0] cand;
  logic [1:0]        scan_state;
  logic              unused_data_in;

  assign wr             = stb & we;
  assign rd             = stb & ~we;
  assign proc_sel       = data_in[12:8];
  assign rise           = rdy_in & ~rdy_q;
  assign avail          = pending_q & mask_q;
  assign hold           = (scan_state == ST_HOLD);
  assign clr_all        = wr & data_in[CTRL_CLR];
  assign claim_acc      = wr & data_in[CTRL_CLAIM] & hold & ~data_in[CTRL_CLR];
  assign ack            = stb;
  assign unused_data_in = ^{data_in[31:13], data_in[7:5]};

  // Priority on a pending bit: clear-all over set (rise/force) over claim.
  always_comb begin
    pending_d = pending_q;
    mask_d    = mask_q;
    if (claim_acc) pending_d[cand] = 1'b0;
    pending_d = pending_d | rise;
    if (wr && data_in[CTRL_FORCE]) pending_d[proc_sel] = 1'b1;
    if (clr_all) pending_d = '0;
    if (wr && data_in[CTRL_EN])  mask_d[proc_sel] = 1'b1;
    if (wr && data_in[CTRL_DIS]) mask_d[proc_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      rdy_q     <= rdy_in;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  proc_ready_sel_rr_scan u_scan (
    .clk     (clk),
    .rst     (rst),
    .avail   (avail),
    .claim   (claim_acc),
    .clr_all (clr_all),
    .state_o (scan_state),
    .cand_o  (cand)
  );

  always_comb begin
    data_out = '0;
    if (rd) begin
      data_out[VALID_BIT]              = hold;
      data_out[CAND_LSB +: SCAN_W]     = cand;
      data_out[15:0]                   = avail[15:0];
    end
  end

endmodule
